// File: rtl/pattern_uart_pkg.sv
// Shared definitions for the pattern-byte UART transmitter: FSM encoding and widths.
`timescale 1ns/1ps
package pattern_uart_pkg;

    localparam int DATA_W               = 8;
    localparam int BIT_IDX_W            = 3;
    localparam int DEFAULT_CLKS_PER_BIT = 104;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses bit_tick_o on the last count.
`timescale 1ns/1ps
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    output logic bit_tick_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign bit_tick_o = (cnt_q == LAST_CNT);

    // The tick wraps the count, so every bit period (and every state entry) starts at 0.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr_i || bit_tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pattern_uart_tx.sv
// 8N1/8N2 UART transmitter fed by a valid/ready byte handshake; TX is a registered output.
`timescale 1ns/1ps
module pattern_uart_tx
    import pattern_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] DATA,
    input  logic              VALID,
    output logic              READY,
    output logic              TX,
    output logic              BUSY
);

    localparam logic [BIT_IDX_W-1:0] LAST_DATA_IDX = BIT_IDX_W'(DATA_W - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_STOP_IDX = BIT_IDX_W'(STOP_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [DATA_W-1:0]    shift_q, shift_d;
    logic [BIT_IDX_W-1:0] idx_q, idx_d;
    logic                 tx_q, tx_d;
    logic                 bit_tick;
    logic                 baud_clr;

    // Holding the timer clear while idle makes the start bit begin at count 0.
    assign baud_clr = (state_q == ST_IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_i     (CLK),
        .rst_n_i   (RST_N),
        .clr_i     (baud_clr),
        .bit_tick_o(bit_tick)
    );

    assign READY = RST_N && (state_q == ST_IDLE);
    assign BUSY  = (state_q != ST_IDLE);
    assign TX    = tx_q;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        tx_d    = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (VALID && READY) begin
                    shift_d = DATA;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (bit_tick) begin
                    idx_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_d = shift_q[0];
                if (bit_tick) begin
                    shift_d = {1'b0, shift_q[DATA_W-1:1]};
                    idx_d   = idx_q + BIT_IDX_W'(1);
                    if (idx_q == LAST_DATA_IDX) begin
                        idx_d   = '0;
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                // The bit index is reused to count stop-bit periods.
                if (bit_tick) begin
                    idx_d = idx_q + BIT_IDX_W'(1);
                    if (idx_q == LAST_STOP_IDX) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_pattern_uart_tx.sv
// Self-checking bench: frame waveform model plus a sampling UART receiver model.
`timescale 1ns/1ps
module tb_pattern_uart_tx;

    localparam int CPB1 = 4;
    localparam int CPB2 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n1, valid1, ready1, tx1, busy1;
    logic [7:0] data1;
    logic       rst_n2, valid2, ready2, tx2, busy2;
    logic [7:0] data2;

    int tests_run = 0;
    int failed    = 0;

    logic [7:0] dec_q[$];
    int         frame_err = 0;
    int         rst_cnt   = 0;

    pattern_uart_tx #(.CLKS_PER_BIT(CPB1), .STOP_BITS(1)) dut1 (
        .CLK(clk), .RST_N(rst_n1), .DATA(data1), .VALID(valid1),
        .READY(ready1), .TX(tx1), .BUSY(busy1)
    );

    pattern_uart_tx #(.CLKS_PER_BIT(CPB2), .STOP_BITS(2)) dut2 (
        .CLK(clk), .RST_N(rst_n2), .DATA(data2), .VALID(valid2),
        .READY(ready2), .TX(tx2), .BUSY(busy2)
    );

    // Expected line level k cycles after the first start-bit cycle of a frame.
    function automatic logic frame_bit(input logic [7:0] b, input int cpb, input int k);
        int slot;
        slot = k / cpb;
        if (slot == 0) return 1'b0;
        else if (slot <= 8) return b[slot-1];
        else return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (rst_n1 === 1'b0) rst_cnt <= rst_cnt + 1;
    end

    // Receiver model for dut1: samples mid-bit, abandons a frame if reset occurs.
    initial begin
        forever begin
            @(negedge clk);
            if (tx1 === 1'b0) begin
                int         r0;
                int         j;
                logic [7:0] b;
                logic       ok;
                bit         aborted;
                r0 = rst_cnt;
                aborted = 0;
                ok = 1'b1;
                b = '0;
                for (int s = 1; s <= CPB1/2 + 9*CPB1; s++) begin
                    @(negedge clk);
                    if (rst_cnt != r0) begin
                        aborted = 1;
                        break;
                    end
                    if (s == CPB1/2) begin
                        ok = ok & (tx1 === 1'b0);
                    end else if (s > CPB1/2 && (s - CPB1/2) % CPB1 == 0) begin
                        j = (s - CPB1/2) / CPB1;
                        if (j <= 8) b[j-1] = tx1;
                        else ok = ok & (tx1 === 1'b1);
                    end
                end
                if (!aborted) begin
                    dec_q.push_back(b);
                    if (!ok) frame_err++;
                end
            end
        end
    end

    task automatic test_reset();
        rst_n1 = 1'b0;
        valid1 = 1'b1;
        data1  = 8'hC3;
        repeat (3) begin
            @(negedge clk);
            tests_run++;
            if ({tx1, busy1, ready1} !== 3'b100) begin
                failed++;
                $display("FAIL reset_hold: tx/busy/ready=%b required 100", {tx1, busy1, ready1});
            end
        end
        rst_n1 = 1'b1;
        valid1 = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({tx1, busy1, ready1} !== 3'b101) begin
            failed++;
            $display("FAIL reset_release: tx/busy/ready=%b required 101", {tx1, busy1, ready1});
        end
        @(negedge clk);
        tests_run++;
        if (busy1 !== 1'b0) begin
            failed++;
            $display("FAIL reset_no_accept: busy=%b required 0", busy1);
        end
    endtask

    task automatic test_single();
        logic [7:0] b;
        int         busy_cycles;
        int         fe0;
        b = 8'h55;
        dec_q.delete();
        fe0 = frame_err;
        valid1 = 1'b1;
        data1  = b;
        @(negedge clk);
        tests_run++;
        if (tx1 !== 1'b1 || busy1 !== 1'b1) begin
            failed++;
            $display("FAIL single_latency: tx=%b busy=%b required tx=1 busy=1", tx1, busy1);
        end
        busy_cycles = (busy1 === 1'b1) ? 1 : 0;
        valid1 = 1'b0;
        data1  = 8'hF0;
        for (int k = 0; k < 10*CPB1; k++) begin
            @(negedge clk);
            if (busy1 === 1'b1) busy_cycles++;
            tests_run++;
            if (tx1 !== frame_bit(b, CPB1, k)) begin
                failed++;
                $display("FAIL single_tx[%0d]: got %b required %b", k, tx1, frame_bit(b, CPB1, k));
            end
        end
        tests_run++;
        if (busy_cycles != 10*CPB1 || ready1 !== 1'b1) begin
            failed++;
            $display("FAIL single_busy: busy cycles %0d ready %b required %0d and 1", busy_cycles, ready1, 10*CPB1);
        end
        @(negedge clk);
        tests_run++;
        if (dec_q.size() != 1 || dec_q[0] !== b || frame_err != fe0) begin
            failed++;
            $display("FAIL single_decode: %0d bytes first %h framing errs %0d required 1 byte %h no errs",
                     dec_q.size(), (dec_q.size() > 0) ? dec_q[0] : 8'hxx, frame_err - fe0, b);
        end
    endtask

    task automatic test_back_to_back();
        logic exp;
        int   fe0;
        dec_q.delete();
        fe0 = frame_err;
        valid1 = 1'b1;
        data1  = 8'h00;
        for (int t = 1; t <= 83; t++) begin
            @(negedge clk);
            if (t >= 2 && t <= 41) exp = frame_bit(8'h00, CPB1, t - 2);
            else if (t >= 43 && t <= 82) exp = frame_bit(8'hFF, CPB1, t - 43);
            else exp = 1'b1;
            tests_run++;
            if (tx1 !== exp) begin
                failed++;
                $display("FAIL b2b_tx[%0d]: got %b required %b", t, tx1, exp);
            end
            if (t == 1) data1 = 8'hFF;
            if (t == 42) begin
                data1  = 8'h5A;
                valid1 = 1'b0;
            end
        end
        tests_run++;
        if (dec_q.size() != 2 || dec_q[0] !== 8'h00 || dec_q[1] !== 8'hFF || frame_err != fe0) begin
            failed++;
            $display("FAIL b2b_decode: %0d bytes, framing errs %0d, required 00 FF", dec_q.size(), frame_err - fe0);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        int         fe0;
        b = 8'h3C;
        dec_q.delete();
        fe0 = frame_err;
        valid1 = 1'b1;
        data1  = 8'hA5;
        for (int t = 1; t <= 18; t++) begin
            @(negedge clk);
            if (t == 1) valid1 = 1'b0;
        end
        tests_run++;
        if (tx1 !== 1'b0 || busy1 !== 1'b1) begin
            failed++;
            $display("FAIL rstmid_bit3: tx=%b busy=%b required 0 1", tx1, busy1);
        end
        rst_n1 = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({tx1, busy1, ready1} !== 3'b100) begin
            failed++;
            $display("FAIL rstmid_reset: tx/busy/ready=%b required 100", {tx1, busy1, ready1});
        end
        rst_n1 = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({tx1, busy1, ready1} !== 3'b101) begin
            failed++;
            $display("FAIL rstmid_idle: tx/busy/ready=%b required 101", {tx1, busy1, ready1});
        end
        valid1 = 1'b1;
        data1  = b;
        @(negedge clk);
        valid1 = 1'b0;
        for (int k = 0; k < 10*CPB1; k++) begin
            @(negedge clk);
            tests_run++;
            if (tx1 !== frame_bit(b, CPB1, k)) begin
                failed++;
                $display("FAIL rstmid_tx[%0d]: got %b required %b", k, tx1, frame_bit(b, CPB1, k));
            end
        end
        @(negedge clk);
        tests_run++;
        if (dec_q.size() != 1 || dec_q[0] !== b || frame_err != fe0) begin
            failed++;
            $display("FAIL rstmid_decode: %0d bytes first %h required 1 byte %h",
                     dec_q.size(), (dec_q.size() > 0) ? dec_q[0] : 8'hxx, b);
        end
    endtask

    task automatic test_stop2();
        logic [7:0] b;
        int         busy_cycles;
        int         stop_high;
        b = 8'h80;
        rst_n2 = 1'b0;
        valid2 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n2 = 1'b1;
        @(negedge clk);
        tests_run++;
        if (ready2 !== 1'b1 || tx2 !== 1'b1) begin
            failed++;
            $display("FAIL stop2_idle: ready=%b tx=%b required 1 1", ready2, tx2);
        end
        valid2 = 1'b1;
        data2  = b;
        @(negedge clk);
        busy_cycles = (busy2 === 1'b1) ? 1 : 0;
        stop_high = 0;
        valid2 = 1'b0;
        data2  = 8'h00;
        for (int k = 0; k < 11*CPB2; k++) begin
            @(negedge clk);
            if (busy2 === 1'b1) busy_cycles++;
            if (k >= 9*CPB2 && tx2 === 1'b1) stop_high++;
            tests_run++;
            if (tx2 !== frame_bit(b, CPB2, k)) begin
                failed++;
                $display("FAIL stop2_tx[%0d]: got %b required %b", k, tx2, frame_bit(b, CPB2, k));
            end
        end
        tests_run++;
        if (busy_cycles != 11*CPB2 || stop_high != 2*CPB2) begin
            failed++;
            $display("FAIL stop2_len: busy %0d stop-high %0d required %0d and %0d",
                     busy_cycles, stop_high, 11*CPB2, 2*CPB2);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        int         fe0;
        int         waited;
        dec_q.delete();
        fe0 = frame_err;
        for (int n = 0; n < 200; n++) begin
            int         gap;
            logic [7:0] b;
            gap = $urandom_range(0, 3);
            b   = 8'($urandom);
            if (gap > 0) begin
                valid1 = 1'b0;
                repeat (gap) @(negedge clk);
            end
            valid1 = 1'b1;
            data1  = b;
            waited = 0;
            while (ready1 !== 1'b1 && waited < 100) begin
                @(negedge clk);
                waited++;
            end
            if (ready1 !== 1'b1) begin
                tests_run++;
                failed++;
                $display("FAIL random_ready_timeout: byte %0d ready=%b required 1", n, ready1);
                break;
            end
            exp_q.push_back(b);
            @(negedge clk);
            data1 = 8'($urandom);
        end
        valid1 = 1'b0;
        waited = 0;
        while (dec_q.size() < exp_q.size() && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        repeat (2 * CPB1) @(negedge clk);
        tests_run++;
        if (dec_q.size() != exp_q.size() || frame_err != fe0) begin
            failed++;
            $display("FAIL random_count: decoded %0d framing errs %0d required %0d bytes no errs",
                     dec_q.size(), frame_err - fe0, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < dec_q.size(); i++) begin
            tests_run++;
            if (dec_q[i] !== exp_q[i]) begin
                failed++;
                $display("FAIL random_byte[%0d]: got %h required %h", i, dec_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n1 = 1'b0;
        valid1 = 1'b0;
        data1  = 8'h00;
        rst_n2 = 1'b0;
        valid2 = 1'b0;
        data2  = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid();
        test_stop2();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
